// File: rtl/bf16_mac_result_collector.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// bf16_mac_result_collector: captures bf16 MAC results PIPE_LAT cycles after
// issue, classifies them and buffers them in a credit-protected FIFO. Rev 1.0
// ---------------------------------------------------------------------------
module bf16_mac_result_collector #(
  parameter int PIPE_LAT = 6,
  parameter int DEPTH    = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [15:0]                mac_result,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [15:0]                out_data,
  output logic [3:0]                 out_flags,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       issue_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [PIPE_LAT-1:0] r_track;
  logic [LW-1:0]       r_inflight;
  logic [LW-1:0]       r_level;
  logic [AW-1:0]       r_wptr;
  logic [AW-1:0]       r_rptr;
  logic [19:0]         r_mem [DEPTH];
  logic [19:0]         r_head;
  logic                r_err;

  logic                w_issue;
  logic                w_arrive;
  logic                w_pop;
  logic [LW:0]         w_credit;
  logic [3:0]          w_flags;
  logic [19:0]         w_entry;
  logic [AW-1:0]       w_rptr_nxt;
  logic [LW-1:0]       w_remain;

  assign w_credit   = {1'b0, r_level} + {1'b0, r_inflight};
  assign in_ready   = w_credit < (LW+1)'(DEPTH);
  assign w_issue    = in_valid & in_ready;
  assign w_arrive   = r_track[PIPE_LAT-1];
  assign out_valid  = (r_level != '0);
  assign w_pop      = out_valid & out_ready;
  assign w_entry    = {w_flags, mac_result};
  assign w_rptr_nxt = r_rptr + AW'(w_pop);
  // entries already stored that survive this edge's pop
  assign w_remain   = r_level - LW'(w_pop);

  always_comb begin
    w_flags = 4'b0000;
    if (mac_result[14:7] == 8'hFF) begin
      w_flags = (mac_result[6:0] != 7'd0) ? 4'b1000 : 4'b0100;
    end else if (mac_result[14:7] == 8'h00) begin
      w_flags = (mac_result[6:0] == 7'd0) ? 4'b0010 : 4'b0001;
    end
  end

  always_ff @(posedge clk) begin
    if (w_arrive) r_mem[r_wptr] <= w_entry;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_track    <= '0;
      r_inflight <= '0;
      r_level    <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_head     <= '0;
      r_err      <= 1'b0;
    end else begin
      r_track <= (r_track << 1) | PIPE_LAT'(w_issue);
      case ({w_issue, w_arrive})
        2'b10:   r_inflight <= r_inflight + LW'(1);
        2'b01:   r_inflight <= r_inflight - LW'(1);
        default: r_inflight <= r_inflight;
      endcase
      case ({w_arrive, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
      if (w_arrive) r_wptr <= r_wptr + AW'(1);
      r_rptr <= w_rptr_nxt;
      // head register gives show-ahead output and holds its value when empty
      if (w_remain != '0) r_head <= r_mem[w_rptr_nxt];
      else if (w_arrive)  r_head <= w_entry;
      if (in_valid && !in_ready) r_err <= 1'b1;
    end
  end

  assign out_data  = r_head[15:0];
  assign out_flags = r_head[19:16];
  assign level     = r_level;
  assign issue_err = r_err;

endmodule
`default_nettype wire

// File: tb/tb_bf16_mac_result_collector.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// tb_bf16_mac_result_collector: scoreboard bench with a MAC delay-line model.
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_bf16_mac_result_collector;
  localparam int PIPE_LAT = 6;
  localparam int DEPTH    = 8;
  localparam int LW       = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [15:0]   mac_result;
  logic [15:0]   mac_in;
  logic          out_valid;
  logic          out_ready;
  logic [15:0]   out_data;
  logic [3:0]    out_flags;
  logic [LW-1:0] level;
  logic          issue_err;

  bf16_mac_result_collector #(.PIPE_LAT(PIPE_LAT), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .mac_result(mac_result), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_flags(out_flags), .level(level),
    .issue_err(issue_err)
  );

  always #5 clk = ~clk;

  // MAC stand-in: a pure delay line of PIPE_LAT registers with no stall
  logic [15:0] mac_pipe [PIPE_LAT];
  always @(posedge clk) begin
    mac_pipe[0] <= mac_in;
    for (int i = 1; i < PIPE_LAT; i++) mac_pipe[i] <= mac_pipe[i-1];
  end
  assign mac_result = mac_pipe[PIPE_LAT-1];

  typedef struct { logic [15:0] d; logic [3:0] f; } exp_t;
  exp_t exp_q[$];
  int   arr_q[$];
  int   m_level = 0;
  bit   m_err = 1'b0;
  bit   m_after_rst = 1'b1;
  bit   mon_en = 1'b0;
  int   edge_n = 0;
  int   checks = 0;
  int   fails = 0;

  function automatic logic [3:0] classify(input logic [15:0] v);
    int e;
    int m;
    e = int'(v[14:7]);
    m = int'(v[6:0]);
    if (e == 255) return (m != 0) ? 4'b1000 : 4'b0100;
    if (e == 0)   return (m == 0) ? 4'b0010 : 4'b0001;
    return 4'b0000;
  endfunction

  function automatic logic [15:0] rand_bf16();
    logic [15:0] v;
    v = 16'($urandom);
    case ($urandom_range(3))
      0: v[14:7] = 8'h00;
      1: v[14:7] = 8'hFF;
      default: ;
    endcase
    if ($urandom_range(1) == 1) v[6:0] = 7'd0;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  // Monitor: compares DUT against the model, then advances the model across the coming edge
  always @(negedge clk) begin
    if (mon_en) begin
      bit m_ready;
      m_ready = (m_level + arr_q.size()) < DEPTH;
      chk("level", 32'(level), 32'(m_level));
      chk("out_valid", 32'(out_valid), 32'(m_level != 0));
      chk("in_ready", 32'(in_ready), 32'(m_ready));
      chk("issue_err", 32'(issue_err), 32'(m_err));
      chk("credit_invariant", 32'((int'(level) + arr_q.size()) <= DEPTH), 32'd1);
      if (m_after_rst) begin
        chk("reset_out_data", 32'(out_data), 32'd0);
        chk("reset_out_flags", 32'(out_flags), 32'd0);
      end
      if (out_valid === 1'b1) begin
        if (exp_q.size() == 0) chk("unexpected_output", 32'd1, 32'd0);
        else begin
          chk("head_data", 32'(out_data), 32'(exp_q[0].d));
          chk("head_flags", 32'(out_flags), 32'(exp_q[0].f));
        end
      end
      edge_n++;
      m_after_rst = 1'b0;
      if (rst) begin
        exp_q.delete();
        arr_q.delete();
        m_level = 0;
        m_err = 1'b0;
        m_after_rst = 1'b1;
      end else begin
        if (m_level > 0 && out_ready) begin
          m_level--;
          void'(exp_q.pop_front());
        end
        if (in_valid && !m_ready) m_err = 1'b1;
        if (in_valid && m_ready) arr_q.push_back(edge_n + PIPE_LAT);
        if (arr_q.size() > 0 && arr_q[0] == edge_n) begin
          void'(arr_q.pop_front());
          m_level++;
        end
      end
    end
  end

  task automatic step(input logic v, input logic [15:0] d, input logic r);
    @(posedge clk);
    #1;
    rst       = 1'b0;
    in_valid  = v;
    mac_in    = d;
    out_ready = r;
    if (v && in_ready) exp_q.push_back('{d, classify(d)});
  endtask

  task automatic idle(input int n, input logic r);
    for (int i = 0; i < n; i++) step(1'b0, rand_bf16(), r);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0) && (n < 40)) begin
      step(1'b0, rand_bf16(), 1'b1);
      n++;
    end
    idle(2, 1'b0);
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst      = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  logic [15:0] t2_vals [8];

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; mac_in = 16'h0000;
    t2_vals = '{16'h3F80, 16'h7F80, 16'h7FC0, 16'h0000,
                16'h8000, 16'h0001, 16'hC000, 16'h4040};
    repeat (2) @(posedge clk);
    #1;
    rst    = 1'b0;
    mon_en = 1'b1;

    // single issue of 2.0, then consume it
    step(1'b1, 16'h4000, 1'b0);
    idle(PIPE_LAT + 1, 1'b0);
    step(1'b0, 16'h0000, 1'b1);
    idle(2, 1'b0);

    // eight back-to-back issues fill the FIFO
    for (int i = 0; i < 8; i++) step(1'b1, t2_vals[i], 1'b0);
    idle(PIPE_LAT + 1, 1'b0);

    // one pop while issuing against a low in_ready: sticky error, no entry
    step(1'b1, 16'h1234, 1'b1);
    idle(3, 1'b0);
    drain();

    // continuous issue with continuous consumption
    for (int i = 0; i < 100; i++) step(1'b1, 16'(16'h3C00 + i), 1'b1);
    drain();

    // random traffic
    for (int i = 0; i < 2000; i++)
      step(1'($urandom_range(1)), rand_bf16(), ($urandom_range(9) < 6));
    drain();

    // reset with 3 buffered and 2 in flight; stale arrivals must be dropped
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, rand_bf16(), 1'b0);
    idle(PIPE_LAT, 1'b0);
    for (int i = 0; i < 2; i++) step(1'b1, rand_bf16(), 1'b0);
    do_reset();
    idle(PIPE_LAT + 3, 1'b1);
    step(1'b1, 16'h4000, 1'b0);
    idle(PIPE_LAT + 2, 1'b0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
`default_nettype wire
